// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one unified RAM port between IF fetch and MEM load/store.
// MEM has fixed priority; an IF fetch is abandoned when the ID stage redirects fetch.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_cancel,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_len,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  typedef enum logic [2:0] {IDLE, MEM_RD, MEM_WR, IF_RD, DONE} state_t;

  state_t                  state_q, state_d;
  logic [RAM_ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]              n_q, n_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             asm_q, asm_d;
  logic                    if_done_q, if_done_d;
  logic [31:0]             if_inst_q, if_inst_d;
  logic                    mem_done_q, mem_done_d;
  logic [31:0]             mem_rdata_q, mem_rdata_d;
  logic                    busy_q, busy_d;
  logic [RAM_ADDR_W-1:0]   ram_a_q, ram_a_d;
  logic                    ram_wr_q, ram_wr_d;
  logic [7:0]              ram_dout_q, ram_dout_d;

  logic [2:0]              cnt_next;
  logic [2:0]              cap;
  logic [RAM_ADDR_W-1:0]   a_next;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[ADDR_W-1:RAM_ADDR_W], mem_addr[ADDR_W-1:RAM_ADDR_W]};

  assign cnt_next = cnt_q + 3'd1;
  assign cap      = cnt_q - 3'd1;
  // Beat addresses wrap naturally through the RAM_ADDR_W-bit adder.
  assign a_next   = addr_q + {{(RAM_ADDR_W-3){1'b0}}, cnt_next};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_done_d   = 1'b0;
    if_inst_d   = if_inst_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = ram_a_q;
    ram_wr_d    = ram_wr_q;
    ram_dout_d  = ram_dout_q;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d    = mem_we ? MEM_WR : MEM_RD;
          addr_d     = mem_addr[RAM_ADDR_W-1:0];
          n_d        = (mem_len == 2'b00) ? 3'd1 : (mem_len == 2'b01) ? 3'd2 : 3'd4;
          cnt_d      = 3'd0;
          wdata_d    = mem_wdata;
          asm_d      = 32'd0;
          ram_a_d    = mem_addr[RAM_ADDR_W-1:0];
          ram_wr_d   = mem_we;
          ram_dout_d = mem_wdata[7:0];
        end else if (if_req && !if_cancel) begin
          state_d  = IF_RD;
          addr_d   = if_addr[RAM_ADDR_W-1:0];
          n_d      = 3'd4;
          cnt_d    = 3'd0;
          asm_d    = 32'd0;
          ram_a_d  = if_addr[RAM_ADDR_W-1:0];
          ram_wr_d = 1'b0;
        end
      end

      MEM_WR: begin
        cnt_d = cnt_next;
        if (cnt_next < n_q) begin
          ram_a_d    = a_next;
          ram_dout_d = wdata_q[{cnt_next[1:0], 3'b000} +: 8];
        end else begin
          ram_wr_d   = 1'b0;
          state_d    = DONE;
          mem_done_d = 1'b1;
        end
      end

      MEM_RD, IF_RD: begin
        if (state_q == IF_RD && if_cancel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_next;
          if (cnt_next < n_q) begin
            ram_a_d = a_next;
          end
          // RAM data lags the address by one cycle, so byte k lands while cnt is k+1.
          if (cnt_q != 3'd0) begin
            asm_d[{cap[1:0], 3'b000} +: 8] = ram_din;
          end
          if (cnt_q == n_q) begin
            state_d = DONE;
            if (state_q == MEM_RD) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = asm_d;
            end else begin
              if_done_d = 1'b1;
              if_inst_d = asm_d;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      n_q         <= 3'd0;
      cnt_q       <= 3'd0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      if_done_q   <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= 32'd0;
      busy_q      <= 1'b0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      if_done_q   <= if_done_d;
      if_inst_q   <= if_inst_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_inst   = if_inst_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = busy_q;
  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read byte RAM model.
// Inputs change and outputs are sampled on the falling edge; cycle 0 is the request cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_cancel = 1'b0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = 2'b00;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [16:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  logic [7:0]  ram [0:131071];
  logic        pl_en = 1'b0;
  logic [16:0] pl_addr = 17'd0;
  logic [7:0]  pl_data = 8'd0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .RAM_ADDR_W(17)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy), .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  task automatic preload(input logic [16:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, if_done, mem_done, ram_wr} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_ctrl got %b want 0000", {busy, if_done, mem_done, ram_wr});
    end
    checks++;
    if ({ram_a, ram_dout, if_inst, mem_rdata} !== 89'd0) begin
      errors++; $display("[TB] FAIL reset_data got a=%h dout=%h inst=%h rdata=%h want 0", ram_a, ram_dout, if_inst, mem_rdata);
    end
  endtask

  task automatic test_if_fetch;
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        checks++;
        if (ram_a !== 17'h100 + 17'(c - 1) || ram_wr !== 1'b0) begin
          errors++; $display("[TB] FAIL if_beat%0d got a=%h wr=%b want a=%h wr=0", c, ram_a, ram_wr, 17'h100 + 17'(c - 1));
        end
      end
      checks++;
      if (if_done !== (c == 6) || busy !== (c != 7)) begin
        errors++; $display("[TB] FAIL if_ctrl c%0d got done=%b busy=%b want done=%b busy=%b", c, if_done, busy, c == 6, c != 7);
      end
      if (c == 6) begin
        checks++;
        if (if_inst !== 32'h00100513) begin
          errors++; $display("[TB] FAIL if_inst got %h want 00100513", if_inst);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_simultaneous;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      checks++;
      if (mem_done !== (c == 3) || if_done !== (c == 10)) begin
        errors++; $display("[TB] FAIL sim_done c%0d got mem=%b if=%b want mem=%b if=%b", c, mem_done, if_done, c == 3, c == 10);
      end
      if (c == 1 || c == 5) begin
        checks++;
        if (ram_a !== ((c == 1) ? 17'h200 : 17'h100)) begin
          errors++; $display("[TB] FAIL sim_addr c%0d got %h", c, ram_a);
        end
      end
      if (c == 4) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("[TB] FAIL sim_gap got busy=%b want 0", busy);
        end
      end
      if (c == 3) begin
        checks++;
        if (mem_rdata !== 32'h000000F5) begin
          errors++; $display("[TB] FAIL sim_rdata got %h want 000000f5", mem_rdata);
        end
        mem_req = 1'b0;
      end
      if (c == 10) begin
        checks++;
        if (if_inst !== 32'h00100513) begin
          errors++; $display("[TB] FAIL sim_inst got %h want 00100513", if_inst);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_half_store;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b01; mem_addr = 32'h1FFFF; mem_wdata = 32'hAABBCCDD;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      case (c)
        1: begin
          checks++;
          if ({ram_wr, ram_a, ram_dout} !== {1'b1, 17'h1FFFF, 8'hDD}) begin
            errors++; $display("[TB] FAIL hs_beat0 got wr=%b a=%h d=%h want 1 1ffff dd", ram_wr, ram_a, ram_dout);
          end
        end
        2: begin
          checks++;
          if ({ram_wr, ram_a, ram_dout} !== {1'b1, 17'h00000, 8'hCC}) begin
            errors++; $display("[TB] FAIL hs_beat1 got wr=%b a=%h d=%h want 1 00000 cc", ram_wr, ram_a, ram_dout);
          end
        end
        3: begin
          checks++;
          if (mem_done !== 1'b1 || ram_wr !== 1'b0 || ram_a !== 17'h0) begin
            errors++; $display("[TB] FAIL hs_done got done=%b wr=%b a=%h want 1 0 00000", mem_done, ram_wr, ram_a);
          end
          mem_req = 1'b0;
        end
        default: begin
          checks++;
          if (ram[17'h1FFFF] !== 8'hDD || ram[17'h0] !== 8'hCC || ram[17'h1FFFE] !== 8'h5A) begin
            errors++; $display("[TB] FAIL hs_ram got %h %h %h want dd cc 5a", ram[17'h1FFFF], ram[17'h0], ram[17'h1FFFE]);
          end
        end
      endcase
    end
    mem_we = 1'b0;
  endtask

  task automatic test_cancel;
    if_req = 1'b1; if_addr = 32'h400;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (if_done !== (c == 9)) begin
        errors++; $display("[TB] FAIL cancel_done c%0d got %b want %b", c, if_done, c == 9);
      end
      if (c == 2) if_cancel = 1'b1;
      if (c == 3) begin
        checks++;
        if (busy !== 1'b0 || ram_a !== 17'h401 || if_inst !== 32'h00100513) begin
          errors++; $display("[TB] FAIL cancel_idle got busy=%b a=%h inst=%h want 0 401 00100513", busy, ram_a, if_inst);
        end
        if_cancel = 1'b0; if_addr = 32'h300;
      end
      if (c == 9) begin
        checks++;
        if (if_inst !== 32'h00500293) begin
          errors++; $display("[TB] FAIL cancel_refetch got %h want 00500293", if_inst);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h500; mem_wdata = 32'h44332211;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      checks++;
      if (mem_done !== (c == 5 || c == 11) || busy !== (c != 6)) begin
        errors++; $display("[TB] FAIL b2b c%0d got done=%b busy=%b want done=%b busy=%b", c, mem_done, busy, c == 5 || c == 11, c != 6);
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (ram_wr !== (c == 7) || (c == 7 && ram_a !== 17'h500)) begin
          errors++; $display("[TB] FAIL b2b_regrant c%0d got wr=%b a=%h", c, ram_wr, ram_a);
        end
      end
      if (c == 11) mem_req = 1'b0;
    end
    mem_we = 1'b0;
  endtask

  task automatic test_reset_mid;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h200;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, mem_done, if_done, ram_wr, ram_a, ram_dout, if_inst, mem_rdata} !== 93'd0) begin
      errors++; $display("[TB] FAIL rstmid_out got busy=%b a=%h inst=%h rdata=%h want all 0", busy, ram_a, if_inst, mem_rdata);
    end
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_done !== 1'b0) begin
        errors++; $display("[TB] FAIL rstmid_after c%0d got busy=%b done=%b want 0 0", c, busy, mem_done);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    preload(17'h100, 8'h13); preload(17'h101, 8'h05);
    preload(17'h102, 8'h10); preload(17'h103, 8'h00);
    preload(17'h200, 8'hF5); preload(17'h201, 8'h00);
    preload(17'h202, 8'h00); preload(17'h203, 8'h00);
    preload(17'h300, 8'h93); preload(17'h301, 8'h02);
    preload(17'h302, 8'h50); preload(17'h303, 8'h00);
    preload(17'h400, 8'h11); preload(17'h401, 8'h22);
    preload(17'h1FFFE, 8'h5A); preload(17'h1FFFF, 8'h00); preload(17'h0, 8'h00);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_if_fetch;
    test_simultaneous;
    test_half_store;
    test_cancel;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single byte-wide unified RAM port between instruction fetch (IF stage) and load/store (MEM stage) of the 5-stage RISC-V pipeline. Serialises each request into 1/2/4 byte beats, assembles little-endian read data, and returns a one-cycle done pulse to the requester. MEM has fixed priority over IF. An IF transaction is cancelled when the ID-stage jump_flag redirects fetch.

Parameters:
ADDR_W, 32, width of requester byte addresses
RAM_ADDR_W, 17, width of ram_a; requester addresses truncated to this width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  IF fetch request, held until if_done observed
if_addr  in  ADDR_W  fetch byte address
if_cancel  in  1  jump_flag from ID; aborts IF transaction in flight
if_done  out  1  one-cycle pulse, if_inst valid
if_inst  out  32  fetched instruction, little-endian
mem_req  in  1  MEM request, held until mem_done observed
mem_we  in  1  1 = store, 0 = load
mem_len  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_addr  in  ADDR_W  load/store byte address
mem_wdata  in  32  store data, low bytes used
mem_done  out  1  one-cycle pulse
mem_rdata  out  32  load data, zero-extended raw bytes; MEM stage sign-extends
busy  out  1  high whenever state != IDLE
ram_a  out  RAM_ADDR_W  RAM byte address
ram_wr  out  1  RAM write strobe
ram_dout  out  8  byte to RAM
ram_din  in  8  byte from RAM, valid one cycle after ram_a presented with ram_wr=0

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; beat counter, address and assembly registers 0; any transaction discarded, no done issued.
- States: IDLE, MEM_RD, MEM_WR, IF_RD, DONE. All outputs registered.
- IDLE arbitration, sampled at clock edge:
  - mem_req=1 wins: -> MEM_WR if mem_we, else MEM_RD.
  - Else if_req=1 and if_cancel=0: -> IF_RD.
  - Else stay. Address, len and wdata latched at grant.
- N = beats: IF 4; MEM 1/2/4 per mem_len.
- Grant in cycle 0 -> beat k (k=0..N-1) drives ram_a = (addr+k) mod 2^RAM_ADDR_W in cycle 1+k.
- Write beats: ram_wr=1 and ram_dout = wdata[8k+7:8k] in cycle 1+k. mem_done=1 in cycle N+1; state DONE for that cycle.
- Read beats: ram_wr=0. Byte k captured from ram_din at end of cycle 2+k into bits [8k+7:8k]; unused upper bytes 0.
  - done pulse in cycle N+2 (DONE state), data stable in that cycle and held until the next grant of the same requester.
  - Word read: request cycle 0 -> done cycle 6.
- ram_wr=0 and ram_a holds last value outside write beats.
- DONE lasts exactly one cycle and ignores all requests; -> IDLE. Requesters drop req after seeing done, so a still-high req in the cycle after DONE is a new transaction.
- if_cancel=1 in any IF_RD cycle: stop issuing beats at that edge, -> IDLE directly, no if_done, in-flight ram_din bytes discarded, if_inst unchanged. Arbitration resumes the cycle after.
- if_cancel has no effect in MEM_RD/MEM_WR/DONE.
- Address wrap: beat addresses wrap modulo 2^RAM_ADDR_W, no fault.
- busy=1 in all non-IDLE states; pipeline control uses it together with the requesters' own pending flags.

Test Plan:
- Reset mid-op: word load in progress, rst=0 in cycle 3 -> all outputs 0 immediately; after release, state IDLE and no done.
- IF word fetch: RAM[0x100..0x103]=13,05,10,00, if_req at 0x100 -> ram_a 0x100..0x103 in cycles 1-4, if_done in cycle 6 with if_inst=0x00100513.
- Simultaneous requests: mem_req load-byte at 0x200 (RAM=0xF5) and if_req together -> MEM served first, mem_rdata=0x000000F5, mem_done cycle 3. IF granted in the cycle after DONE, if_done 6 cycles later.
- Half store: mem_wdata=0xAABBCCDD, len=01, addr 0x1FFFF -> ram_wr beats to 0x1FFFF=DD then 0x00000=CC (wrap), mem_done cycle 3, RAM[0x1FFFE] untouched.
- Cancel: IF fetch granted, if_cancel=1 in cycle 2 -> no if_done, busy=0 in cycle 3, if_inst unchanged. A new if_req at 0x300 then completes normally.
- Back-to-back: requester keeps mem_req high through DONE cycle -> second grant occurs the cycle after DONE, never during DONE.
